// File: rtl/al_accel_pkg.sv
// Shared types, default widths and the output saturation helper for the PU array.
package al_accel_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_W, RUN} state_e;

  localparam int unsigned DefDw   = 8;
  localparam int unsigned DefAccw = 32;
  // Width of the saturation helper's operand; accumulators are sign-extended into it.
  localparam int unsigned SatW    = 64;

  // Clamp v to the signed range of a w-bit value.
  function automatic logic signed [SatW-1:0] sat_to_w(input logic signed [SatW-1:0] v,
                                                      input int unsigned w);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = signed'((64'd1 << (w - 1)) - 64'd1);
    lo = ~hi;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/al_accel_pu_array_if.sv
// Weight-load, activation and result handshakes of the PU array.
interface al_accel_pu_array_if #(
  parameter int unsigned K     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned OUT_W = 16
);
  logic              wld_valid;
  logic              wld_ready;
  logic [K*DW-1:0]   wld_data;
  logic              in_valid;
  logic              in_ready;
  logic [K*DW-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [K*OUT_W-1:0] out_data;

  modport master (
    output wld_valid, wld_data, in_valid, in_data, out_ready,
    input  wld_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  wld_valid, wld_data, in_valid, in_data, out_ready,
    output wld_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/al_accel_pu_dot.sv
// Combinational K-lane signed dot product: one weight row times the activation vector.
module al_accel_pu_dot #(
  parameter int unsigned K    = 3,
  parameter int unsigned DW   = 8,
  parameter int unsigned ACCW = 32
) (
  input  logic [K*DW-1:0]        w_row,
  input  logic [K*DW-1:0]        x,
  output logic signed [ACCW-1:0] y
);

  logic signed [2*DW-1:0] prod [K];

  for (genvar c = 0; c < K; c++) begin : g_lane
    assign prod[c] = (2*DW)'($signed(w_row[c*DW +: DW])) * (2*DW)'($signed(x[c*DW +: DW]));
  end

  always_comb begin
    y = '0;
    for (int unsigned c = 0; c < K; c++) begin
      y = y + ACCW'(prod[c]);
    end
  end

endmodule

// File: rtl/al_accel_pu_array.sv
// Weight-stationary KxK matrix-vector PU with grouped accumulation and a valid/ready result.
// Define AL_ACCEL_PU_SAT_EN to saturate output lanes instead of truncating them.
module al_accel_pu_array
  import al_accel_pkg::*;
#(
  parameter int unsigned K     = 3,
  parameter int unsigned DW    = DefDw,
  parameter int unsigned ACCW  = DefAccw,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enb,
  input  logic [CNT_W-1:0] acc_len,
  output logic             busy,
  al_accel_pu_array_if.slave bus
);

  localparam int unsigned RowW = (K > 1) ? $clog2(K) : 1;

  if (ACCW < 2 * DW + $clog2(K) + CNT_W) begin : g_accw_chk
    $error("ACCW too narrow for the worst-case accumulation");
  end
  if (ACCW > SatW) begin : g_satw_chk
    $error("ACCW wider than the saturation helper");
  end

  state_e                 state_q;
  logic [RowW-1:0]        row_q;
  logic [RowW-1:0]        wld_idx;
  logic [CNT_W-1:0]       len_q;
  logic [CNT_W-1:0]       beat_q;
  logic [CNT_W-1:0]       eff_len;
  logic [K*DW-1:0]        w_q   [K];
  logic signed [ACCW-1:0] acc_q [K];
  logic signed [ACCW-1:0] dot   [K];
  logic signed [ACCW-1:0] sum   [K];
  logic [K*OUT_W-1:0]     out_q;
  logic [K*OUT_W-1:0]     conv;
  logic                   out_valid_q;
  logic                   is_last;
  logic                   at_boundary;
  logic                   wld_fire;
  logic                   in_fire;

  assign eff_len     = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign is_last     = (beat_q == len_q - CNT_W'(1));
  assign at_boundary = (beat_q == '0) && !out_valid_q;
  assign wld_idx     = (state_q == LOAD_W) ? row_q : '0;

  assign bus.wld_ready = !reset && enb &&
                         ((state_q == IDLE) || (state_q == LOAD_W) ||
                          ((state_q == RUN) && at_boundary));
  // Stall only a last beat whose result would overwrite an undrained output.
  assign bus.in_ready  = (state_q == RUN) && enb &&
                         !(out_valid_q && !bus.out_ready && is_last);

  assign wld_fire      = bus.wld_valid && bus.wld_ready;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_q;
  assign busy          = (state_q != IDLE);

  for (genvar r = 0; r < K; r++) begin : g_row
    al_accel_pu_dot #(
      .K    (K),
      .DW   (DW),
      .ACCW (ACCW)
    ) u_dot (
      .w_row (w_q[r]),
      .x     (bus.in_data),
      .y     (dot[r])
    );

    assign sum[r] = acc_q[r] + dot[r];

`ifdef AL_ACCEL_PU_SAT_EN
    logic signed [SatW-1:0] sat;
    assign sat = sat_to_w(SatW'(sum[r]), OUT_W);
    assign conv[r*OUT_W +: OUT_W] = sat[OUT_W-1:0];
`else
    assign conv[r*OUT_W +: OUT_W] = sum[r][OUT_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      for (int unsigned r = 0; r < K; r++) begin
        w_q[r]   <= '0;
        acc_q[r] <= '0;
      end
    end else begin
      if (in_fire) begin
        if (is_last) begin
          out_q  <= conv;
          beat_q <= '0;
          for (int unsigned r = 0; r < K; r++) acc_q[r] <= '0;
        end else begin
          beat_q <= beat_q + CNT_W'(1);
          for (int unsigned r = 0; r < K; r++) acc_q[r] <= sum[r];
        end
      end

      if (in_fire && is_last) begin
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (wld_fire) begin
        w_q[wld_idx] <= bus.wld_data;
        if (wld_idx == RowW'(K - 1)) begin
          state_q <= RUN;
          row_q   <= '0;
          len_q   <= eff_len;
          beat_q  <= '0;
        end else begin
          state_q <= LOAD_W;
          row_q   <= wld_idx + RowW'(1);
        end
      end
    end
  end

endmodule

// File: doc/al_accel_pu_array.md
Name: al_accel_pu_array

Overview:
Parametrised successor to the fixed 3x3 int8 processing unit. The block is weight-stationary and computes a KxK signed-weight matrix times a K-lane signed activation vector. It accumulates the result over a programmable number of input beats, then emits K results through a valid/ready output. It sits between the accelerator's weight/activation buffers and the output writeback path.

Parameters:
K, 3, matrix rows/cols and activation lanes
DW, 8, signed weight/activation width
ACCW, 32, signed accumulator width; must be >= 2*DW+clog2(K)+CNT_W (elaboration check)
OUT_W, 16, signed output lane width
CNT_W, 8, width of accumulation-length counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous reset, active-high
enb  in  1  enables weight/input handshakes; output handshake unaffected
acc_len  in  CNT_W  beats per accumulation group; sampled on entry to RUN; 0 treated as 1
wld_valid  in  1  weight row valid
wld_ready  out  1  weight row accepted when valid&ready
wld_data  in  K*DW  one weight row; lane c at [c*DW +: DW] = w[row][c]
in_valid  in  1  activation vector valid
in_ready  out  1  activation accepted when valid&ready
in_data  in  K*DW  lane c = x[c]
out_valid  out  1  result valid, held until out_ready
out_ready  in  1  downstream accept
out_data  out  K*OUT_W  lane r = y[r]
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, weights/accumulators/counters 0; wld_ready=0 while reset is high; in_ready=0, out_valid=0, out_data=0, busy=0.
- States:
  - IDLE: wld_ready=enb. First accepted row goes to row 0 and moves the block to LOAD_W.
  - LOAD_W: wld_ready=enb. Row index increments per accepted beat. After row K-1 is accepted, acc_len is latched, the group beat counter clears, and the block moves to RUN.
  - RUN: accepts activations. Reload is permitted only at a group boundary (beat_cnt==0 and out_valid==0); wld_ready=enb there, and an accepted row is written to row 0 and moves the block to LOAD_W. Otherwise wld_ready=0.
- Per accepted beat: acc[r] += sum_c w[r][c]*x[c]. Signed DW x DW products are sign-extended to ACCW and wrap modulo 2^ACCW.
- Last beat of a group (beat_cnt==len-1):
  - acc[r] plus the current beat's contribution is converted to OUT_W and loaded into out_data.
  - out_valid rises the cycle after the accepting edge (latency 1).
  - acc and beat_cnt clear.
- The output register is separate from the accumulators, so the next group may accumulate while the output is pending.
- in_ready = (state==RUN) & enb & !(out_valid & !out_ready & beat_cnt==len-1). A last beat is therefore never lost; when out_ready is high, the last beat and the output drain occur in the same cycle.
- out_valid clears on out_valid&out_ready unless a new last beat is accepted in the same cycle, in which case it stays high with the new data.
- enb low freezes the counters and state; the output may still drain.
- Reset mid-operation discards partial accumulation, pending output and weights.
- OUT_W conversion: see Optional Feature.

Optional Feature:
- AL_ACCEL_PU_SAT_EN defined: each output lane saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Undefined: each output lane is the low OUT_W bits of the accumulator (two's-complement wrap).

Decomposition:
- Package al_accel_pkg:
  - state enum (IDLE, LOAD_W, RUN)
  - default DW/ACCW constants
  - sat_to_w function (used only under the macro)
- Sub-module al_accel_pu_dot: combinational K-lane signed dot product (one weight row times x, ACCW result), instantiated K times.

Test Plan:
1. Load rows {-10,64,85},{13,-120,-91},{20,17,-100}; acc_len=1; x={91,-19,12}; out_ready=1 -> out_data={-1106,2371,297}, out_valid high exactly 1 cycle after accept.
2. Same weights, acc_len=2, x sent twice -> single output {-2212,4742,594}; no out_valid after first beat.
3. All weights -128, x={-128,-128,-128}, acc_len=1 (sum 49152) -> with AL_ACCEL_PU_SAT_EN all lanes 32767; without it all lanes -16384.
4. acc_len=1, out_ready=0, two vectors offered -> first result held; in_ready=0 until out_ready=1. Raise out_ready -> drain and second accept in the same cycle; second result valid next cycle.
5. acc_len=2; assert reset after first beat -> same cycle: out_valid=0, in_ready=0, busy=0; after release the block needs a weight reload; a vector sent without reload is not accepted.
6. After a group completes and drains, offer a new weight row in RUN -> wld_ready=1, state LOAD_W. Mid-group (beat_cnt=1) offer -> wld_ready=0.
